pc_shot_scheduler: RTL and testbench

//  Sequences the PC's attack during pc_turn_State: picks a target cell on tablero_jugador,

---
 rtl/pc_shot_scheduler_pkg.sv | 32 +++
 rtl/pc_shot_scheduler_if.sv | 32 +++
 rtl/pc_shot_scheduler_lfsr8.sv | 31 +++
 rtl/pc_shot_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_pc_shot_scheduler.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_shot_scheduler_pkg.sv
// Shared types for the PC shot scheduler: board cell codes, FSM states,
// and the small combinational helpers used by the scheduler and its LFSR.
package pc_shot_scheduler_pkg;

  localparam int BOARD_N = 5;

  typedef enum logic [1:0] {
    CELL_WATER = 2'b00,
    CELL_SHIP  = 2'b01,
    CELL_MISS  = 2'b10,
    CELL_HIT   = 2'b11
  } cell_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PICK  = 3'd1,
    CHECK = 3'd2,
    SCAN  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } pc_shot_state_t;

  // Fibonacci form of x^8+x^6+x^5+x^4+1, shifting toward the MSB
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic is_shootable(input cell_t c);
    return (c == CELL_WATER) || (c == CELL_SHIP);
  endfunction

endpackage

// File: rtl/pc_shot_scheduler_if.sv
// Request/response and board-access signals between FSMgame (master) and
// the PC shot scheduler (slave); the master side also owns tablero_jugador.
interface pc_shot_scheduler_if;

  logic       new_game;
  logic       start;
  logic [2:0] rd_i;
  logic [2:0] rd_j;
  logic [1:0] rd_data;
  logic       wr_en;
  logic [2:0] wr_i;
  logic [2:0] wr_j;
  logic [1:0] wr_data;
  logic       busy;
  logic       shot_done;
  logic       shot_hit;
  logic       no_target;
  logic [4:0] hit_count;

  modport master (
    output new_game, start, rd_data,
    input  rd_i, rd_j, wr_en, wr_i, wr_j, wr_data,
    input  busy, shot_done, shot_hit, no_target, hit_count
  );

  modport slave (
    input  new_game, start, rd_data,
    output rd_i, rd_j, wr_en, wr_i, wr_j, wr_data,
    output busy, shot_done, shot_hit, no_target, hit_count
  );

endinterface

// File: rtl/pc_shot_scheduler_lfsr8.sv
// 8-bit targeting LFSR: advances only when enabled, reseeds synchronously,
// and returns to SEED on the asynchronous reset.
module pc_shot_scheduler_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       reseed,
  output logic [7:0] state
);
  import pc_shot_scheduler_pkg::*;

  logic [7:0] state_r;

  // LFSR register; reseed wins over enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= SEED;
    end else if (reseed) begin
      state_r <= SEED;
    end else if (enable) begin
      state_r <= lfsr8_next(state_r);
    end else begin
      state_r <= state_r;
    end
  end

  assign state = state_r;

endmodule

// File: rtl/pc_shot_scheduler.sv
// PC attack sequencer: random picks with bounded retries, then a row-major
// scan fallback; writes one HIT/MISS per shot and tracks the PC hit count.
module pc_shot_scheduler #(
  parameter int         BOARD_N   = 5,
  parameter int         MAX_TRIES = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  pc_shot_scheduler_if.slave bus
);
  import pc_shot_scheduler_pkg::*;

  localparam int              TW       = $clog2(MAX_TRIES + 1);
  localparam logic [3:0]      N_LIM    = 4'(BOARD_N);
  localparam logic [2:0]      LAST_IDX = 3'(BOARD_N - 1);
  localparam logic [TW-1:0]   LAST_TRY = TW'(MAX_TRIES - 1);

  pc_shot_state_t state_r, state_n;
  logic [TW-1:0]  tries_r, tries_n;
  logic [2:0]     cur_i_r, cur_i_n;
  logic [2:0]     cur_j_r, cur_j_n;
  logic           shot_hit_r, shot_hit_n;
  logic           no_target_r, no_target_n;
  logic [1:0]     wr_data_r, wr_data_n;
  logic [4:0]     hit_count_r, hit_count_n;
  logic           busy_r;
  logic           wr_en_r;
  logic           shot_done_r;

  logic           lfsr_en_s;
  logic [7:0]     lfsr_s;
  logic [1:0]     lfsr_unused_s;
  logic [2:0]     cand_i_s;
  logic [2:0]     cand_j_s;
  logic           cand_oor_s;
  cell_t          cell_s;
  logic           shootable_s;

  pc_shot_scheduler_lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .enable (lfsr_en_s),
    .reseed (bus.new_game),
    .state  (lfsr_s)
  );

  assign cand_i_s      = lfsr_s[2:0];
  assign cand_j_s      = lfsr_s[5:3];
  assign lfsr_unused_s = lfsr_s[7:6];
  assign cand_oor_s    = ({1'b0, cand_i_s} >= N_LIM) || ({1'b0, cand_j_s} >= N_LIM);
  assign cell_s        = cell_t'(bus.rd_data);
  assign shootable_s   = is_shootable(cell_s);

  // Next-state logic; new_game aborts any shot in flight and clears the tally
  always_comb begin
    state_n     = state_r;
    tries_n     = tries_r;
    cur_i_n     = cur_i_r;
    cur_j_n     = cur_j_r;
    shot_hit_n  = shot_hit_r;
    no_target_n = no_target_r;
    wr_data_n   = wr_data_r;
    hit_count_n = hit_count_r;
    lfsr_en_s   = 1'b0;

    if (bus.new_game) begin
      state_n     = IDLE;
      tries_n     = '0;
      hit_count_n = 5'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_n     = PICK;
            tries_n     = '0;
            shot_hit_n  = 1'b0;
            no_target_n = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end
        PICK: begin
          lfsr_en_s = 1'b1;
          if (!cand_oor_s) begin
            cur_i_n = cand_i_s;
            cur_j_n = cand_j_s;
            state_n = CHECK;
          end else if (tries_r == LAST_TRY) begin
            cur_i_n = 3'd0;
            cur_j_n = 3'd0;
            state_n = SCAN;
          end else begin
            tries_n = tries_r + TW'(1);
          end
        end
        CHECK: begin
          if (shootable_s) begin
            state_n    = WRITE;
            shot_hit_n = (cell_s == CELL_SHIP);
            wr_data_n  = (cell_s == CELL_SHIP) ? CELL_HIT : CELL_MISS;
          end else if (tries_r == LAST_TRY) begin
            cur_i_n = 3'd0;
            cur_j_n = 3'd0;
            state_n = SCAN;
          end else begin
            tries_n = tries_r + TW'(1);
            state_n = PICK;
          end
        end
        SCAN: begin
          if (shootable_s) begin
            state_n    = WRITE;
            shot_hit_n = (cell_s == CELL_SHIP);
            wr_data_n  = (cell_s == CELL_SHIP) ? CELL_HIT : CELL_MISS;
          end else if ((cur_i_r == LAST_IDX) && (cur_j_r == LAST_IDX)) begin
            state_n     = DONE;
            no_target_n = 1'b1;
          end else if (cur_j_r == LAST_IDX) begin
            cur_j_n = 3'd0;
            cur_i_n = cur_i_r + 3'd1;
          end else begin
            cur_j_n = cur_j_r + 3'd1;
          end
        end
        WRITE: begin
          state_n = DONE;
          if (shot_hit_r && (hit_count_r != 5'd31)) begin
            hit_count_n = hit_count_r + 5'd1;
          end else begin
            hit_count_n = hit_count_r;
          end
        end
        DONE: begin
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // State and output registers; strobes are decoded from the next state so they align with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      tries_r     <= '0;
      cur_i_r     <= 3'd0;
      cur_j_r     <= 3'd0;
      shot_hit_r  <= 1'b0;
      no_target_r <= 1'b0;
      wr_data_r   <= 2'b00;
      hit_count_r <= 5'd0;
      busy_r      <= 1'b0;
      wr_en_r     <= 1'b0;
      shot_done_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      tries_r     <= tries_n;
      cur_i_r     <= cur_i_n;
      cur_j_r     <= cur_j_n;
      shot_hit_r  <= shot_hit_n;
      no_target_r <= no_target_n;
      wr_data_r   <= wr_data_n;
      hit_count_r <= hit_count_n;
      busy_r      <= (state_n == PICK) || (state_n == CHECK) ||
                     (state_n == SCAN) || (state_n == WRITE);
      wr_en_r     <= (state_n == WRITE);
      shot_done_r <= (state_n == DONE);
    end
  end

  assign bus.rd_i      = cur_i_r;
  assign bus.rd_j      = cur_j_r;
  assign bus.wr_en     = wr_en_r;
  assign bus.wr_i      = cur_i_r;
  assign bus.wr_j      = cur_j_r;
  assign bus.wr_data   = wr_data_r;
  assign bus.busy      = busy_r;
  assign bus.shot_done = shot_done_r;
  assign bus.shot_hit  = shot_hit_r;
  assign bus.no_target = no_target_r;
  assign bus.hit_count = hit_count_r;

endmodule

// File: tb/tb_pc_shot_scheduler.sv
// Self-checking bench for pc_shot_scheduler: a board model answers reads,
// and a targeting model pushes the expected outcome of every shot to a queue.
module tb_pc_shot_scheduler;
  import pc_shot_scheduler_pkg::*;

  localparam int         N       = 5;
  localparam int         MT      = 8;
  localparam logic [7:0] SEED    = 8'hA5;
  localparam int         MAX_LAT = 2 * MT + N * N + 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pc_shot_scheduler_if bus ();

  pc_shot_scheduler #(
    .BOARD_N   (N),
    .MAX_TRIES (MT),
    .LFSR_SEED (SEED)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [1:0] board [N][N];
  int         wcnt  [N][N];

  assign bus.rd_data = ((bus.rd_i < 3'(N)) && (bus.rd_j < 3'(N))) ?
                       board[bus.rd_i][bus.rd_j] : 2'b10;

  typedef struct {
    bit         nt;
    bit         hit;
    int         i;
    int         j;
    logic [1:0] d;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] m_lfsr;
  int         exp_hits;
  int         n_checks;
  int         n_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] m_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [31:0] outs();
    return {8'd0, bus.busy, bus.wr_en, bus.shot_done, bus.shot_hit, bus.no_target,
            bus.hit_count, bus.rd_i, bus.rd_j, bus.wr_i, bus.wr_j, bus.wr_data};
  endfunction

  task automatic fill(input logic [1:0] c);
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++) board[a][b] = c;
  endtask

  // expected outcome of the next shot, advancing the model LFSR once per pick
  task automatic predict(output exp_t e);
    int tries = 0;
    bit found = 0;
    logic [7:0] v;
    int ci, cj;
    e.nt = 0; e.hit = 0; e.i = 0; e.j = 0; e.d = 2'b00;
    while (!found && tries < MT) begin
      v = m_lfsr;
      m_lfsr = m_step(m_lfsr);
      ci = int'(v[2:0]);
      cj = int'(v[5:3]);
      if (ci < N && cj < N && board[ci][cj] < 2'd2) begin
        found = 1; e.i = ci; e.j = cj;
      end else begin
        tries++;
      end
    end
    for (int a = 0; a < N && !found; a++)
      for (int b = 0; b < N && !found; b++)
        if (board[a][b] < 2'd2) begin
          found = 1; e.i = a; e.j = b;
        end
    if (!found) begin
      e.nt = 1;
    end else begin
      e.hit = (board[e.i][e.j] == 2'b01);
      e.d   = e.hit ? 2'b11 : 2'b10;
    end
  endtask

  task automatic run_shot(input string tag, input bit spam);
    exp_t e, g;
    int cyc = 1;
    bit done = 0;
    int nw = 0;
    int wi = 0, wj = 0;
    logic [1:0] wd = 2'b00;
    predict(e);
    exp_q.push_back(e);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    while (!done && cyc <= MAX_LAT + 10) begin
      if (bus.wr_en) begin
        nw++;
        wi = int'(bus.wr_i); wj = int'(bus.wr_j); wd = bus.wr_data;
        if (wi < N && wj < N) begin
          wcnt[wi][wj]++;
          board[wi][wj] = wd;
        end
      end
      if (bus.shot_done) begin
        done = 1;
      end else begin
        if (spam) bus.start = bus.busy;
        @(negedge clk);
        cyc++;
      end
    end
    bus.start = 1'b0;
    g = exp_q.pop_front();
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_latency_ok"}, 32'(cyc <= MAX_LAT), 32'd1);
    check_eq({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_no_target"}, 32'(bus.no_target), 32'(g.nt));
    if (g.nt) begin
      check_eq({tag, "_writes"}, 32'(nw), 32'd0);
    end else begin
      check_eq({tag, "_writes"}, 32'(nw), 32'd1);
      check_eq({tag, "_wr_addr"}, 32'(wi * 8 + wj), 32'(g.i * 8 + g.j));
      check_eq({tag, "_wr_data"}, 32'(wd), 32'(g.d));
      check_eq({tag, "_shot_hit"}, 32'(bus.shot_hit), 32'(g.hit));
    end
    if (g.hit && exp_hits < 31) exp_hits++;
    check_eq({tag, "_hit_count"}, 32'(bus.hit_count), 32'(exp_hits));
  endtask

  initial begin
    int cyc;
    int ships;
    int ev;
    logic [7:0] tmp;
    n_checks = 0; n_err = 0;
    bus.start = 1'b0; bus.new_game = 1'b0;
    fill(2'b00);
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++) wcnt[a][b] = 0;
    m_lfsr = SEED; exp_hits = 0;

    repeat (3) @(negedge clk);
    check_eq("reset_outputs", outs(), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("idle_not_busy", 32'(bus.busy), 32'd0);

    // 1: asynchronous reset while the write strobe is high
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    cyc = 0;
    while (!bus.wr_en && cyc < MAX_LAT + 10) begin
      @(negedge clk); cyc++;
    end
    check_eq("t1_write_reached", 32'(bus.wr_en), 32'd1);
    #1 rst = 1'b0;
    #1 check_eq("t1_async_clear", outs(), 32'd0);
    @(negedge clk); rst = 1'b1;
    m_lfsr = SEED; exp_hits = 0;

    // 2: ship at the first in-range pick from the seed
    tmp = SEED;
    while (int'(tmp[2:0]) >= N || int'(tmp[5:3]) >= N) tmp = m_step(tmp);
    fill(2'b00);
    board[int'(tmp[2:0])][int'(tmp[5:3])] = 2'b01;
    run_shot("t2", 1'b0);

    // 3: only (4,4) shootable, forcing the scan fallback in practice
    fill(2'b10);
    board[4][4] = 2'b00;
    run_shot("t3", 1'b0);

    // 4: nothing left to shoot
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++) board[a][b] = ((a + b) % 2 == 1) ? 2'b11 : 2'b10;
    run_shot("t4", 1'b0);

    // 5a: start held high while busy
    fill(2'b00);
    run_shot("t5a", 1'b1);
    repeat (3) @(negedge clk);
    check_eq("t5a_no_restart", 32'(bus.busy), 32'd0);

    // 5b: new_game during CHECK aborts the shot
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    cyc = 0;
    while (dut.state_r != CHECK && cyc < MAX_LAT + 10) begin
      @(negedge clk); cyc++;
    end
    check_eq("t5b_reached_check", 32'(dut.state_r == CHECK), 32'd1);
    bus.new_game = 1'b1;
    @(negedge clk); bus.new_game = 1'b0;
    check_eq("t5b_busy_dropped", 32'(bus.busy), 32'd0);
    ev = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.wr_en || bus.shot_done) ev++;
      @(negedge clk);
    end
    check_eq("t5b_no_write_or_done", 32'(ev), 32'd0);
    check_eq("t5b_hit_count", 32'(bus.hit_count), 32'd0);
    m_lfsr = SEED; exp_hits = 0;

    // 6: exhaust a random board
    ships = 0;
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++) begin
        board[a][b] = 2'($urandom_range(0, 1));
        if (board[a][b] == 2'b01) ships++;
        wcnt[a][b] = 0;
      end
    for (int k = 0; k < N * N; k++) run_shot($sformatf("t6_s%0d", k), 1'b0);
    check_eq("t6_hits_eq_ships", 32'(bus.hit_count), 32'(ships));
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++)
        check_eq($sformatf("t6_once_%0d_%0d", a, b), 32'(wcnt[a][b]), 32'd1);
    run_shot("t6_last", 1'b0);
    check_eq("t6_last_no_target", 32'(bus.no_target), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
